// File: rtl/tanh_backward_pkg.sv
// rtl/tanh_backward_pkg.sv - shared constants and FSM encoding for the tanh backward block
// Contents: default datapath widths, lane count, and the controller state type.
package tanh_backward_pkg;

    localparam int DEF_HID_DIM = 24;   // matrix side
    localparam int DEF_N_LEN   = 16;   // gradient width (signed)
    localparam int DEF_N_FRAC  = 8;    // gradient fraction bits
    localparam int DEF_N_LEN_W = 8;    // activation width (signed)
    localparam int DEF_W_FRAC  = 6;    // activation fraction bits, 1.0 = 64
    localparam int TANH_BW_PAR = 8;    // elements per beat
    localparam int STATE_LEN   = 2;

    typedef enum logic [STATE_LEN-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } tbw_state_e;

endpackage

// File: rtl/tanh_backward_if.sv
// rtl/tanh_backward_if.sv - operand/result bundle for the tanh backward block
// Signals: load, run (commands), y_in (activations), d (upstream gradient),
//          valid, q (input gradient result).
// Modports: master drives commands/operands, slave drives valid/q.
interface tanh_backward_if #(
    parameter int N       = 576,
    parameter int N_LEN   = 16,
    parameter int N_LEN_W = 8
);
    logic                   load;
    logic                   run;
    logic [N*N_LEN_W-1:0]   y_in;
    logic [N*N_LEN-1:0]     d;
    logic                   valid;
    logic [N*N_LEN-1:0]     q;

    modport master (output load, run, y_in, d, input valid, q);
    modport slave  (input load, run, y_in, d, output valid, q);
endinterface

// File: rtl/tanh_backward_lane.sv
// rtl/tanh_backward_lane.sv - one element of dx = dy * (1 - y^2), pipelined
// Ports: clk, rst (sync, active-high); y_i activation, d_i upstream gradient;
//        r_o saturated result, valid two edges after the operands are sampled
//        (the third stage is the write into q in the parent).
module tanh_backward_lane #(
    parameter int N_LEN   = 16,
    parameter int N_FRAC  = 8,
    parameter int N_LEN_W = 8,
    parameter int W_FRAC  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [N_LEN_W-1:0] y_i,
    input  logic signed [N_LEN-1:0]   d_i,
    output logic        [N_LEN-1:0]   r_o
);
    localparam int SW     = 2 * N_LEN_W;      // y*y width
    localparam int TW     = SW + 1;           // 1 - y^2 needs one extra bit
    localparam int PW     = N_LEN + TW;       // full-precision product width
    localparam int P_FRAC = N_FRAC + 2 * W_FRAC;
    localparam int SH     = P_FRAC - N_FRAC;  // back to gradient scaling

    localparam logic signed [TW-1:0] ONE_SQ = TW'(1) <<< (2 * W_FRAC);

    logic signed [SW-1:0] s;
    logic signed [TW-1:0] t_d, t_q;
    logic signed [N_LEN-1:0] d1_q;
    logic signed [PW-1:0] p_d, p_q;
    logic signed [PW-1:0] r_full;
    logic [PW-N_LEN:0] hi;

    // Stage 1: t = 1 - y^2 (negative when |y| > 1.0)
    assign s   = SW'(y_i) * SW'(y_i);
    assign t_d = ONE_SQ - TW'(s);

    // Stage 2: full-precision product
    assign p_d = PW'(d1_q) * PW'(t_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q  <= '0;
            d1_q <= '0;
            p_q  <= '0;
        end else begin
            t_q  <= t_d;
            d1_q <= d_i;
            p_q  <= p_d;
        end
    end

    // Stage 3: arithmetic shift floors; result fits only if the bits above the
    // gradient sign bit are all copies of it.
    assign r_full = p_q >>> SH;
    assign hi     = r_full[PW-1:N_LEN-1];

    always_comb begin
        r_o = r_full[N_LEN-1:0];
        if (!((&hi) || (~|hi))) begin
            r_o = r_full[PW-1] ? {1'b1, {(N_LEN-1){1'b0}}}
                               : {1'b0, {(N_LEN-1){1'b1}}};
        end
    end

endmodule

// File: rtl/tanh_backward.sv
// rtl/tanh_backward.sv - tanh backward pass: q = d * (1 - y^2), PAR lanes per beat
// Ports: clk, rst (sync, active-high); bus (slave): load captures y_in,
//        run captures d and starts, valid/q carry the completed result.
module tanh_backward
    import tanh_backward_pkg::*;
#(
    parameter int HID_DIM = DEF_HID_DIM,
    parameter int N_LEN   = DEF_N_LEN,
    parameter int N_FRAC  = DEF_N_FRAC,
    parameter int N_LEN_W = DEF_N_LEN_W,
    parameter int W_FRAC  = DEF_W_FRAC,
    parameter int PAR     = TANH_BW_PAR
) (
    input  logic          clk,
    input  logic          rst,
    tanh_backward_if.slave bus
);
    localparam int N     = HID_DIM * HID_DIM;
    localparam int BEATS = N / PAR;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    tbw_state_e state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic valid_q, valid_d;
    logic load_y, cap_d, issue;

    logic [N*N_LEN_W-1:0] y_buf_q;
    logic [N*N_LEN-1:0]   d_buf_q;
    logic [N*N_LEN-1:0]   q_q;

    // Beat index travels with the data so write-back knows its slots.
    logic          v1_q, v2_q;
    logic [BW-1:0] beat1_q, beat2_q;

    logic [N_LEN-1:0] r_lane [PAR];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        load_y  = 1'b0;
        cap_d   = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.load) begin
                    load_y  = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.run) begin
                    cap_d   = 1'b1;
                    valid_d = 1'b0;
                    beat_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                issue  = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(BEATS - 1)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Finish once the last beat has been written back.
                if (!v1_q && !v2_q) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            valid_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            beat1_q <= '0;
            beat2_q <= '0;
            y_buf_q <= '0;
            d_buf_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            v1_q    <= issue;
            v2_q    <= v1_q;
            beat1_q <= beat_q;
            beat2_q <= beat1_q;
            if (load_y) y_buf_q <= bus.y_in;
            if (cap_d)  d_buf_q <= bus.d;
        end
    end

    for (genvar l = 0; l < PAR; l++) begin : g_lane
        logic [N_LEN_W-1:0] y_sel;
        logic [N_LEN-1:0]   d_sel;

        assign y_sel = y_buf_q[(int'(beat_q) * PAR + l) * N_LEN_W +: N_LEN_W];
        assign d_sel = d_buf_q[(int'(beat_q) * PAR + l) * N_LEN +: N_LEN];

        tanh_backward_lane #(
            .N_LEN   (N_LEN),
            .N_FRAC  (N_FRAC),
            .N_LEN_W (N_LEN_W),
            .W_FRAC  (W_FRAC)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .y_i (y_sel),
            .d_i (d_sel),
            .r_o (r_lane[l])
        );
    end

    // Slots outside the current beat keep their previous contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (v2_q) begin
            for (int l = 0; l < PAR; l++) begin
                q_q[(int'(beat2_q) * PAR + l) * N_LEN +: N_LEN] <= r_lane[l];
            end
        end
    end

    assign bus.valid = valid_q;
    assign bus.q     = q_q;

endmodule
